// File: rtl/servo_pkg.sv
// servo_pkg
// Shared definitions for the servo path. The pixel-to-PWM mapping stage and
// the PWM generator both import this package so that they agree on the
// width type and on the legal pulse-width limits.
//   pwm_width_t  : 21-bit pulse width in clock cycles
//   DEFAULT_*    : frame length and per-axis limits at 100 MHz
//   clampWidth   : limits a commanded width to [lo, hi]
//   centreWidth  : midpoint of a legal range, used as the reset position
package servo_pkg;

   typedef logic [20:0] pwm_width_t;

   localparam int DEFAULT_PERIOD   = 2000000;
   localparam int DEFAULT_MIN_W_X  = 125000;
   localparam int DEFAULT_MAX_W_X  = 375000;
   localparam int DEFAULT_MIN_W_Y  = 155000;
   localparam int DEFAULT_MAX_W_Y  = 290000;
   localparam int DEFAULT_MAX_STEP = 0;

   // The comparison is done on 22-bit signed copies so a large unsigned
   // command can never be mistaken for a small one.
   function automatic pwm_width_t clampWidth(input pwm_width_t w,
                                             input pwm_width_t lo,
                                             input pwm_width_t hi);
      logic signed [21:0] wSigned;
      logic signed [21:0] loSigned;
      logic signed [21:0] hiSigned;
      wSigned  = signed'({1'b0, w});
      loSigned = signed'({1'b0, lo});
      hiSigned = signed'({1'b0, hi});
      if (wSigned < loSigned) begin
         return lo;
      end else if (wSigned > hiSigned) begin
         return hi;
      end
      return w;
   endfunction

   function automatic pwm_width_t centreWidth(input int lo, input int hi);
      return pwm_width_t'((lo + hi) / 2);
   endfunction

endpackage

// File: rtl/servo_pwm_gen_channel.sv
// servo_channel
// One servo axis: clamps incoming commands, holds the pending width, moves
// the active width toward it at each frame boundary (optionally slew
// limited) and drives the registered pin.
//   clk_in / rst_n_in : clock, synchronous active-low reset
//   valid_in, cmd_in  : new command for this axis
//   boundary_in       : high in the last cycle of a frame
//   next_count_in     : frame counter value for the coming cycle
//   next_enabled_in   : enable state for the coming cycle
//   pin_out           : PWM pin
//   width_out         : width currently being generated
module servo_channel
   import servo_pkg::*;
#(
   parameter int MIN_W    = DEFAULT_MIN_W_X,
   parameter int MAX_W    = DEFAULT_MAX_W_X,
   parameter int MAX_STEP = DEFAULT_MAX_STEP,
   parameter int CNT_W    = 21
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             valid_in,
   input  pwm_width_t       cmd_in,
   input  logic             boundary_in,
   input  logic [CNT_W-1:0] next_count_in,
   input  logic             next_enabled_in,
   output logic             pin_out,
   output pwm_width_t       width_out
);

   localparam pwm_width_t         MIN_V    = pwm_width_t'(MIN_W);
   localparam pwm_width_t         MAX_V    = pwm_width_t'(MAX_W);
   localparam pwm_width_t         CENTRE_V = centreWidth(MIN_W, MAX_W);
   localparam logic signed [21:0] STEP_S   = 22'(MAX_STEP);

   pwm_width_t         clampedCmd;
   pwm_width_t         targetWidth;
   pwm_width_t         nextActive;
   pwm_width_t         pendingWidth;
   pwm_width_t         activeWidth;
   logic signed [21:0] activeSigned;
   logic signed [21:0] delta;

   // Work out where the active width goes at the boundary. A command arriving
   // in the boundary cycle itself bypasses the pending register so that it is
   // not delayed by a whole frame. With a nonzero step the width moves at most
   // STEP_S per frame toward the target; the target is already clamped, so the
   // result stays inside the legal range.
   always_comb begin
      clampedCmd   = clampWidth(cmd_in, MIN_V, MAX_V);
      targetWidth  = valid_in ? clampedCmd : pendingWidth;
      activeSigned = signed'({1'b0, activeWidth});
      delta        = signed'({1'b0, targetWidth}) - activeSigned;
      nextActive   = activeWidth;
      if (boundary_in) begin
         if ((MAX_STEP != 0) && (delta > STEP_S)) begin
            nextActive = pwm_width_t'(activeSigned + STEP_S);
         end else if ((MAX_STEP != 0) && (delta < -STEP_S)) begin
            nextActive = pwm_width_t'(activeSigned - STEP_S);
         end else begin
            nextActive = targetWidth;
         end
      end
   end

   // Pending/active registers and the pin. The pin is computed from the
   // counter, enable and width that will hold in the coming cycle, so it is
   // registered yet still rises exactly in the cnt==0 cycle.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         pendingWidth <= CENTRE_V;
         activeWidth  <= CENTRE_V;
         pin_out      <= 1'b0;
      end else begin
         if (valid_in) begin
            pendingWidth <= clampedCmd;
         end
         activeWidth <= nextActive;
         pin_out     <= next_enabled_in && (32'(next_count_in) < 32'(nextActive));
      end
   end

   assign width_out = activeWidth;

endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen
// Two-axis servo PWM generator. A free-running frame counter produces one
// pulse per servo per frame; commands take effect only at frame boundaries.
//   clk_in, rst_n_in      : clock, synchronous active-low reset
//   enable_in             : pulse enable, taken at frame boundaries
//   valid_in, pwm_x_in/y  : new width commands (cycles)
//   servo_x_out/y_out     : PWM pins
//   frame_start_out       : strobe in the first cycle of each frame
//   width_x_out/y_out     : widths currently being generated
module servo_pwm_gen
   import servo_pkg::*;
#(
   parameter int PERIOD   = DEFAULT_PERIOD,
   parameter int MIN_W_X  = DEFAULT_MIN_W_X,
   parameter int MAX_W_X  = DEFAULT_MAX_W_X,
   parameter int MIN_W_Y  = DEFAULT_MIN_W_Y,
   parameter int MAX_W_Y  = DEFAULT_MAX_W_Y,
   parameter int MAX_STEP = DEFAULT_MAX_STEP
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        enable_in,
   input  logic        valid_in,
   input  logic [20:0] pwm_x_in,
   input  logic [20:0] pwm_y_in,
   output logic        servo_x_out,
   output logic        servo_y_out,
   output logic        frame_start_out,
   output logic [20:0] width_x_out,
   output logic [20:0] width_y_out
);

   localparam int CNT_W = $clog2(PERIOD);

   logic [CNT_W-1:0] frameCount;
   logic [CNT_W-1:0] nextCount;
   logic             boundary;
   logic             enabled;
   logic             nextEnabled;

   // The last cycle of a frame is the boundary; the counter wraps there and
   // the enable input is only looked at on that edge.
   always_comb begin
      boundary    = (frameCount == CNT_W'(PERIOD - 1));
      nextCount   = boundary ? '0 : frameCount + CNT_W'(1);
      nextEnabled = boundary ? enable_in : enabled;
   end

   // Frame counter, enable latch and the frame-start strobe, which is high
   // in the cycle where the counter reads zero after a wrap.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         frameCount      <= '0;
         enabled         <= 1'b0;
         frame_start_out <= 1'b0;
      end else begin
         frameCount      <= nextCount;
         enabled         <= nextEnabled;
         frame_start_out <= boundary;
      end
   end

   servo_channel #(
      .MIN_W    (MIN_W_X),
      .MAX_W    (MAX_W_X),
      .MAX_STEP (MAX_STEP),
      .CNT_W    (CNT_W)
   ) xChannel (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .valid_in        (valid_in),
      .cmd_in          (pwm_x_in),
      .boundary_in     (boundary),
      .next_count_in   (nextCount),
      .next_enabled_in (nextEnabled),
      .pin_out         (servo_x_out),
      .width_out       (width_x_out)
   );

   servo_channel #(
      .MIN_W    (MIN_W_Y),
      .MAX_W    (MAX_W_Y),
      .MAX_STEP (MAX_STEP),
      .CNT_W    (CNT_W)
   ) yChannel (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .valid_in        (valid_in),
      .cmd_in          (pwm_y_in),
      .boundary_in     (boundary),
      .next_count_in   (nextCount),
      .next_enabled_in (nextEnabled),
      .pin_out         (servo_y_out),
      .width_out       (width_y_out)
   );

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen
// Bench for servo_pwm_gen with a short frame. Two instances share every
// input: one with unlimited slew and one limited to 30 cycles per frame.
// A reference model tracks frame position, enable, pending and active widths
// from the behavioural rules and every cycle is compared against it; frame
// level pulse lengths are also measured and compared with fixed values.
module tb_servo_pwm_gen;

   localparam int PERIOD = 1000;
   localparam int MINW   = 100;
   localparam int MAXW   = 300;
   localparam int STEPS  = 30;
   localparam int CENTRE = 200;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        enable_in = 1'b0;
   logic        valid_in = 1'b0;
   logic [20:0] pwm_x_in = '0;
   logic [20:0] pwm_y_in = '0;

   logic        servo_x_out, servo_y_out, frame_start_out;
   logic [20:0] width_x_out, width_y_out;
   logic        slewX, slewY, slewFs;
   logic [20:0] slewWx, slewWy;

   int   errors = 0;
   int   checks = 0;

   logic curRst = 1'b0;
   logic curEn  = 1'b0;

   int   mPos;
   logic mEn;
   logic mFs;
   int   mPendX, mPendY, mActX, mActY, mActSX, mActSY;

   typedef struct {
      int x;
      int y;
      int expX;
      int expY;
   } vec_t;

   vec_t vecs[6];

   always #5 clk_in = ~clk_in;

   servo_pwm_gen #(
      .PERIOD(PERIOD), .MIN_W_X(MINW), .MAX_W_X(MAXW),
      .MIN_W_Y(MINW), .MAX_W_Y(MAXW), .MAX_STEP(0)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
      .valid_in(valid_in), .pwm_x_in(pwm_x_in), .pwm_y_in(pwm_y_in),
      .servo_x_out(servo_x_out), .servo_y_out(servo_y_out),
      .frame_start_out(frame_start_out),
      .width_x_out(width_x_out), .width_y_out(width_y_out)
   );

   servo_pwm_gen #(
      .PERIOD(PERIOD), .MIN_W_X(MINW), .MAX_W_X(MAXW),
      .MIN_W_Y(MINW), .MAX_W_Y(MAXW), .MAX_STEP(STEPS)
   ) dutSlew (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
      .valid_in(valid_in), .pwm_x_in(pwm_x_in), .pwm_y_in(pwm_y_in),
      .servo_x_out(slewX), .servo_y_out(slewY),
      .frame_start_out(slewFs),
      .width_x_out(slewWx), .width_y_out(slewWy)
   );

   function automatic int clampW(input int v);
      if (v < MINW) return MINW;
      if (v > MAXW) return MAXW;
      return v;
   endfunction

   function automatic int slewTo(input int cur, input int tgt, input int step);
      if (step != 0 && tgt - cur > step) return cur + step;
      if (step != 0 && cur - tgt > step) return cur - step;
      return tgt;
   endfunction

   task automatic checkValue(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Compares both instances against the model for the current cycle.
   task automatic checkOutput();
      logic ex, ey, esx, esy;
      ex  = mEn && (mPos < mActX);
      ey  = mEn && (mPos < mActY);
      esx = mEn && (mPos < mActSX);
      esy = mEn && (mPos < mActSY);
      checks++;
      if (servo_x_out !== ex || servo_y_out !== ey || frame_start_out !== mFs ||
          int'(width_x_out) != mActX || int'(width_y_out) != mActY) begin
         errors++;
         $display("[TB] FAIL cycle-main pos=%0d: got x=%b y=%b fs=%b wx=%0d wy=%0d, expected x=%b y=%b fs=%b wx=%0d wy=%0d",
                  mPos, servo_x_out, servo_y_out, frame_start_out, width_x_out, width_y_out,
                  ex, ey, mFs, mActX, mActY);
      end
      checks++;
      if (slewX !== esx || slewY !== esy || slewFs !== mFs ||
          int'(slewWx) != mActSX || int'(slewWy) != mActSY) begin
         errors++;
         $display("[TB] FAIL cycle-slew pos=%0d: got x=%b y=%b fs=%b wx=%0d wy=%0d, expected x=%b y=%b fs=%b wx=%0d wy=%0d",
                  mPos, slewX, slewY, slewFs, slewWx, slewWy, esx, esy, mFs, mActSX, mActSY);
      end
   endtask

   // Drives one cycle of inputs at the falling edge, advances the model over
   // the rising edge and checks the outputs at the next falling edge.
   task automatic applyStimulus(input logic v, input int x, input int y);
      rst_n_in  = curRst;
      enable_in = curEn;
      valid_in  = v;
      pwm_x_in  = 21'(x);
      pwm_y_in  = 21'(y);
      if (!curRst) begin
         mPos = 0; mEn = 1'b0; mFs = 1'b0;
         mPendX = CENTRE; mPendY = CENTRE;
         mActX = CENTRE; mActY = CENTRE; mActSX = CENTRE; mActSY = CENTRE;
      end else begin
         if (v) begin
            mPendX = clampW(x);
            mPendY = clampW(y);
         end
         if (mPos == PERIOD - 1) begin
            mActX  = slewTo(mActX, mPendX, 0);
            mActY  = slewTo(mActY, mPendY, 0);
            mActSX = slewTo(mActSX, mPendX, STEPS);
            mActSY = slewTo(mActSY, mPendY, STEPS);
            mEn    = curEn;
            mPos   = 0;
            mFs    = 1'b1;
         end else begin
            mPos++;
            mFs = 1'b0;
         end
      end
      @(posedge clk_in);
      @(negedge clk_in);
      valid_in = 1'b0;
      checkOutput();
   endtask

   task automatic runTo(input int target);
      int guard;
      guard = 0;
      while (mPos != target && guard < 3 * PERIOD) begin
         applyStimulus(1'b0, 0, 0);
         guard++;
      end
      checkValue("runTo-position", mPos, target);
   endtask

   // Steps through one whole frame starting from its boundary cycle and
   // counts high cycles on all four pins. cmdCnt/enCnt select the counter
   // value of the cycle in which a command or an enable change is applied.
   task automatic measureFrame(input int cmdCnt, input int x, input int y,
                               input int enCnt, input logic enVal,
                               output int hx, output int hy,
                               output int hsx, output int hsy);
      int cur;
      hx = 0; hy = 0; hsx = 0; hsy = 0;
      if (mPos != PERIOD - 1) runTo(PERIOD - 1);
      for (int k = 0; k < PERIOD; k++) begin
         cur = (k == 0) ? PERIOD - 1 : k - 1;
         if (cur == enCnt) curEn = enVal;
         applyStimulus(cur == cmdCnt, x, y);
         if (servo_x_out) hx++;
         if (servo_y_out) hy++;
         if (slewX) hsx++;
         if (slewY) hsy++;
      end
   endtask

   task automatic doReset();
      curRst = 1'b0;
      applyStimulus(1'b0, 0, 0);
      applyStimulus(1'b0, 0, 0);
      curRst = 1'b1;
   endtask

   initial begin
      int hx, hy, hsx, hsy, cnt, x, y;
      logic v;
      int slewExp[5];

      vecs[0] = '{x: 50,      y: 400,     expX: 100, expY: 300};
      vecs[1] = '{x: 0,       y: 2097151, expX: 100, expY: 300};
      vecs[2] = '{x: 2097151, y: 0,       expX: 300, expY: 100};
      vecs[3] = '{x: 100,     y: 300,     expX: 100, expY: 300};
      vecs[4] = '{x: 299,     y: 101,     expX: 299, expY: 101};
      vecs[5] = '{x: 1048676, y: 99,      expX: 300, expY: 100};
      slewExp = '{230, 260, 290, 300, 300};

      @(negedge clk_in);

      // Reset state, then enable with no commands.
      doReset();
      checkValue("reset-width-x", int'(width_x_out), CENTRE);
      checkValue("reset-width-y", int'(width_y_out), CENTRE);
      checkValue("reset-pins", int'({servo_x_out, servo_y_out, frame_start_out}), 0);
      curEn = 1'b1;
      measureFrame(-1, 0, 0, -1, 1'b1, hx, hy, hsx, hsy);
      checkValue("first-frame-x", hx, CENTRE);
      checkValue("first-frame-y", hy, CENTRE);

      // Mid-frame command takes effect in the next frame.
      measureFrame(500, 250, 120, -1, 1'b1, hx, hy, hsx, hsy);
      checkValue("latency-current-x", hx, CENTRE);
      checkValue("latency-current-y", hy, CENTRE);
      measureFrame(-1, 0, 0, -1, 1'b1, hx, hy, hsx, hsy);
      checkValue("latency-next-x", hx, 250);
      checkValue("latency-next-y", hy, 120);

      // Clamp vectors.
      for (int i = 0; i < 6; i++) begin
         measureFrame(int'($urandom_range(0, PERIOD - 2)), vecs[i].x, vecs[i].y, -1, 1'b1,
                      hx, hy, hsx, hsy);
         measureFrame(-1, 0, 0, -1, 1'b1, hx, hy, hsx, hsy);
         checkValue($sformatf("clamp%0d-pulse-x", i), hx, vecs[i].expX);
         checkValue($sformatf("clamp%0d-pulse-y", i), hy, vecs[i].expY);
         checkValue($sformatf("clamp%0d-width-x", i), int'(width_x_out), vecs[i].expX);
         checkValue($sformatf("clamp%0d-width-y", i), int'(width_y_out), vecs[i].expY);
      end

      // Command in the boundary cycle applies to the very next frame.
      measureFrame(PERIOD - 1, 150, 200, -1, 1'b1, hx, hy, hsx, hsy);
      checkValue("bypass-x", hx, 150);
      checkValue("bypass-y", hy, 200);

      // Enable dropped mid-frame: current pulse completes, later frames idle.
      measureFrame(PERIOD - 1, 200, 200, -1, 1'b1, hx, hy, hsx, hsy);
      checkValue("pre-disable-x", hx, 200);
      measureFrame(-1, 0, 0, 100, 1'b0, hx, hy, hsx, hsy);
      checkValue("disable-current-x", hx, 200);
      checkValue("disable-current-y", hy, 200);
      measureFrame(-1, 0, 0, -1, 1'b0, hx, hy, hsx, hsy);
      checkValue("disabled-x", hx, 0);
      checkValue("disabled-y", hy, 0);

      // Reset in the middle of a pulse.
      curEn = 1'b1;
      measureFrame(-1, 0, 0, -1, 1'b1, hx, hy, hsx, hsy);
      checkValue("reenable-x", hx, 200);
      runTo(50);
      checkValue("pre-reset-pin-x", int'(servo_x_out), 1);
      curRst = 1'b0;
      applyStimulus(1'b0, 0, 0);
      curRst = 1'b1;
      checkValue("midreset-pins", int'({servo_x_out, servo_y_out}), 0);
      checkValue("midreset-width-x", int'(width_x_out), CENTRE);
      checkValue("midreset-width-y", int'(width_y_out), CENTRE);
      cnt = 0;
      while (mPos != PERIOD - 1) begin
         applyStimulus(1'b0, 0, 0);
         if (servo_x_out || servo_y_out) cnt++;
      end
      checkValue("post-reset-idle-frame", cnt, 0);
      measureFrame(-1, 0, 0, -1, 1'b1, hx, hy, hsx, hsy);
      checkValue("post-reset-pulse-x", hx, CENTRE);

      // Slew-limited approach from 200 to 300.
      measureFrame(500, 300, 200, -1, 1'b1, hx, hy, hsx, hsy);
      checkValue("slew-start-x", hsx, CENTRE);
      for (int f = 0; f < 5; f++) begin
         measureFrame(-1, 0, 0, -1, 1'b1, hx, hy, hsx, hsy);
         checkValue($sformatf("slew-frame%0d-x", f), hsx, slewExp[f]);
         checkValue($sformatf("slew-frame%0d-y", f), hsy, CENTRE);
         checkValue($sformatf("slew-frame%0d-main-x", f), hx, 300);
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 15 * PERIOD; c++) begin
         v = ($urandom_range(0, 299) == 0);
         x = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 400))
                                         : int'($urandom_range(0, 2097151));
         y = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 400))
                                         : int'($urandom_range(0, 2097151));
         if ($urandom_range(0, 1499) == 0) curEn = ~curEn;
         curRst = ($urandom_range(0, 4999) != 0);
         applyStimulus(v, x, y);
      end
      curRst = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
